cls_vote_unit: RTL and testbench
================================

Name: cls_vote_unit

Overview:
Parametrised N-way lockstep voter and fault manager for redundant core clusters. It takes NUM_CH replicated output buses (master = channel 0), each packed WIDTH bits wide, and produces a registered bitwise-majority result. It tracks per-channel consecutive disagreements, marks persistent offenders as faulty and excludes them from later votes. A health FSM raises an interrupt toward the cluster handler on degradation or failure.

Parameters:
NUM_CH, 3, number of redundant channels; legal range 3..8.
WIDTH, 32, width of one channel's compare bus.
ERR_THRESH, 4, consecutive disagreeing samples that mark a channel faulty; at least 1.
CNT_W, 8, width of the saturating global mismatch counter.

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
enable_i  in  1  compare enable; when low, samples are ignored and all state is held
sample_i  in  1  qualifies ch_data_i this cycle
ch_data_i  in  NUM_CH*WIDTH  channel k at [k*WIDTH +: WIDTH]
clear_i  in  1  clears all sticky fault state
irq_ack_i  in  1  acknowledges irq_o
voted_o  out  WIDTH  registered majority value
voted_valid_o  out  1  one-cycle pulse; voted_o is valid
mismatch_o  out  1  one-cycle pulse; some healthy channel disagreed with the vote
ch_fault_o  out  NUM_CH  sticky faulty-channel mask
err_cnt_o  out  CNT_W  saturating count of mismatching samples
state_o  out  2  OK=0, MISMATCH=1, DEGRADED=2, FAIL=3
fail_o  out  1  high in FAIL
irq_o  out  1  level interrupt

Behaviour:
- One clock, clk_i. Reset is synchronous and active-low on rst_ni.
- Reset values: voted_o=0, voted_valid_o=0, mismatch_o=0, ch_fault_o=0, err_cnt_o=0, state_o=OK, fail_o=0, irq_o=0. All disagree counters are 0.
- Sample event: sample_i && enable_i && !clear_i.
- Vote (healthy channels only, i.e. ch_fault_o bit = 0):
  - Each bit takes the value held by a strict majority (> healthy/2).
  - If any bit has no strict majority, the sample is unresolvable.
- Latency: voted_o, voted_valid_o and mismatch_o update on the clock edge after the sample event, i.e. 1 cycle.
- Per-channel disagree counter, healthy channels only:
  - ch_data != vote: counter increments, saturating at ERR_THRESH.
  - Otherwise: counter clears.
  - Reaching ERR_THRESH sets ch_fault_o[k] in that same update. The mask is sticky.
- err_cnt_o increments by 1 per sample with any healthy disagreement and saturates at 2^CNT_W-1.
- FSM, evaluated on sample events using the updated mask:
  - In FAIL: hold FAIL.
  - Unresolvable sample, or healthy count < 2: go to FAIL.
  - Mask nonzero: go to DEGRADED.
  - Any counter nonzero: go to MISMATCH.
  - Otherwise: go to OK.
  - DEGRADED never returns to OK or MISMATCH without clear_i.
- In FAIL: voted_valid_o=0, voted_o holds its last value, fail_o=1. Counters and mask are frozen.
- irq_o:
  - Set on every entry into DEGRADED, on every new fault bit set, and on entry into FAIL.
  - Cleared by irq_ack_i.
  - A set event and irq_ack_i in the same cycle leave irq_o=1 (event wins).
- clear_i has priority over everything except reset. Next cycle: mask, counters, err_cnt_o and irq_o = 0; state=OK; voted_valid_o=0; a coincident sample is discarded.
- enable_i low mid-sequence: counters are held, not cleared.

Optional Feature:
CLS_FINJ_EN
- Defined: adds ports finj_fault_i (1 bit), finj_ch_i ($clog2(NUM_CH) bits) and finj_bit_i ($clog2(WIDTH) bits).
  - When finj_fault_i=1, bit finj_bit_i of channel finj_ch_i is XOR-inverted combinationally before voting and counting.
  - Out-of-range finj_ch_i has no effect.
- Undefined: these ports are absent and the data path is untouched.

Test Plan:
1. Defaults (NUM_CH=3, ERR_THRESH=4). All channels 0xDEADBEEF, sample every cycle -> voted_o=0xDEADBEEF with voted_valid_o one cycle later; state OK; mismatch_o=0; err_cnt_o=0.
2. ch1 = 0xDEADBEAF for one sample, then agreeing -> mismatch_o one pulse, err_cnt_o=1, state MISMATCH then OK; ch_fault_o=0.
3. ch2 = 0 for 4 consecutive samples, others 0x12345678 -> voted_o=0x12345678 throughout; ch_fault_o=3'b100 after the 4th; state DEGRADED; irq_o=1 until irq_ack_i.
4. From test 3, ch0=0x1 and ch1=0x2 -> unresolvable -> state FAIL, fail_o=1, voted_valid_o=0. Then clear_i -> ch_fault_o=0, err_cnt_o=0, state OK, irq_o=0.
5. irq_ack_i asserted in the same cycle as the FAIL-entry sample -> irq_o remains 1. enable_i low with a mismatching sample -> no counter or state change.
6. CLS_FINJ_EN defined, all channels 0x0, finj_fault_i=1, finj_ch_i=1, finj_bit_i=31 -> voted_o=0x0, mismatch_o pulse, err_cnt_o=1.

Source files
------------

// File: rtl/cls_vote_unit.sv
// N-way lockstep voter with sticky per-channel fault masking and a health FSM.
// Optional fault injection on the channel inputs is enabled by defining CLS_FINJ_EN.
module cls_vote_unit #(
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ERR_THRESH = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    enable_i,
  input  logic                    sample_i,
  input  logic [NUM_CH*WIDTH-1:0] ch_data_i,
  input  logic                    clear_i,
  input  logic                    irq_ack_i,
`ifdef CLS_FINJ_EN
  input  logic                        finj_fault_i,
  input  logic [$clog2(NUM_CH)-1:0]   finj_ch_i,
  input  logic [$clog2(WIDTH)-1:0]    finj_bit_i,
`endif
  output logic [WIDTH-1:0]        voted_o,
  output logic                    voted_valid_o,
  output logic                    mismatch_o,
  output logic [NUM_CH-1:0]       ch_fault_o,
  output logic [CNT_W-1:0]        err_cnt_o,
  output logic [1:0]              state_o,
  output logic                    fail_o,
  output logic                    irq_o
);

  localparam int unsigned HC_W = $clog2(NUM_CH + 1);
  localparam int unsigned DC_W = $clog2(ERR_THRESH + 1);
`ifdef CLS_FINJ_EN
  localparam int unsigned CH_IW = $clog2(NUM_CH);
`endif

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_MISMATCH = 2'd1,
    ST_DEGRADED = 2'd2,
    ST_FAIL     = 2'd3
  } state_e;

  state_e                       state_q;
  logic [NUM_CH-1:0][DC_W-1:0]  cnt_q;

  logic [WIDTH-1:0]             ch_data [NUM_CH];
  logic [WIDTH-1:0]             vote_c;
  logic                         unres_c;
  logic [HC_W-1:0]              healthy_c;
  logic [HC_W-1:0]              healthy_nxt_c;
  logic [HC_W-1:0]              ones;
  logic [HC_W-1:0]              zeros;
  logic [NUM_CH-1:0]            disagree_c;
  logic [NUM_CH-1:0]            mask_nxt_c;
  logic [NUM_CH-1:0][DC_W-1:0]  cnt_nxt_c;
  state_e                       st_nxt_c;
  logic                         sample_evt_c;
  logic                         irq_set_c;

  // Split the flat bus into channels, optionally flipping one injected bit.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      ch_data[k] = ch_data_i[k*WIDTH +: WIDTH];
`ifdef CLS_FINJ_EN
      if (finj_fault_i && (finj_ch_i == CH_IW'(k))) begin
        ch_data[k] = ch_data[k] ^ (WIDTH'(1) << finj_bit_i);
      end
`endif
    end
  end

  // Bitwise strict-majority vote over healthy channels.
  always_comb begin
    healthy_c = '0;
    vote_c    = '0;
    unres_c   = 1'b0;
    ones      = '0;
    zeros     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      healthy_c = healthy_c + HC_W'(!ch_fault_o[k]);
    end
    for (int b = 0; b < WIDTH; b++) begin
      ones = '0;
      for (int k = 0; k < NUM_CH; k++) begin
        ones = ones + HC_W'(!ch_fault_o[k] && ch_data[k][b]);
      end
      zeros = healthy_c - ones;
      if ({ones, 1'b0} > {1'b0, healthy_c}) begin
        vote_c[b] = 1'b1;
      end else if ({zeros, 1'b0} <= {1'b0, healthy_c}) begin
        unres_c = 1'b1;
      end
    end
  end

  // Disagree counters and fault mask; an unresolvable sample leaves both untouched.
  always_comb begin
    disagree_c    = '0;
    mask_nxt_c    = ch_fault_o;
    cnt_nxt_c     = cnt_q;
    healthy_nxt_c = '0;
    if (!unres_c) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (!ch_fault_o[k]) begin
          if (ch_data[k] != vote_c) begin
            disagree_c[k] = 1'b1;
            if (cnt_q[k] != DC_W'(ERR_THRESH)) cnt_nxt_c[k] = cnt_q[k] + DC_W'(1);
          end else begin
            cnt_nxt_c[k] = '0;
          end
          if (cnt_nxt_c[k] == DC_W'(ERR_THRESH)) mask_nxt_c[k] = 1'b1;
        end
      end
    end
    for (int k = 0; k < NUM_CH; k++) begin
      healthy_nxt_c = healthy_nxt_c + HC_W'(!mask_nxt_c[k]);
    end
  end

  assign sample_evt_c = sample_i && enable_i && (state_q != ST_FAIL);

  always_comb begin
    st_nxt_c  = ST_OK;
    irq_set_c = 1'b0;
    if (unres_c || (healthy_nxt_c < HC_W'(2))) st_nxt_c = ST_FAIL;
    else if (|mask_nxt_c)                        st_nxt_c = ST_DEGRADED;
    else if (|cnt_nxt_c)                         st_nxt_c = ST_MISMATCH;
    if (sample_evt_c) begin
      irq_set_c = (st_nxt_c == ST_FAIL)
               || ((st_nxt_c == ST_DEGRADED) && (state_q != ST_DEGRADED))
               || (|(mask_nxt_c & ~ch_fault_o));
    end
  end

  assign state_o = state_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= ST_OK;
      cnt_q         <= '0;
      voted_o       <= '0;
      voted_valid_o <= 1'b0;
      mismatch_o    <= 1'b0;
      ch_fault_o    <= '0;
      err_cnt_o     <= '0;
      fail_o        <= 1'b0;
      irq_o         <= 1'b0;
    end else if (clear_i) begin
      state_q       <= ST_OK;
      cnt_q         <= '0;
      voted_valid_o <= 1'b0;
      mismatch_o    <= 1'b0;
      ch_fault_o    <= '0;
      err_cnt_o     <= '0;
      fail_o        <= 1'b0;
      irq_o         <= 1'b0;
    end else begin
      voted_valid_o <= 1'b0;
      mismatch_o    <= 1'b0;
      if (sample_evt_c) begin
        state_q <= st_nxt_c;
        fail_o  <= (st_nxt_c == ST_FAIL);
        if (!unres_c) begin
          voted_o       <= vote_c;
          voted_valid_o <= 1'b1;
          mismatch_o    <= |disagree_c;
          cnt_q         <= cnt_nxt_c;
          ch_fault_o    <= mask_nxt_c;
          if ((|disagree_c) && (err_cnt_o != {CNT_W{1'b1}})) err_cnt_o <= err_cnt_o + CNT_W'(1);
        end
      end
      // A set event in the same cycle as an acknowledge wins.
      if (irq_set_c)      irq_o <= 1'b1;
      else if (irq_ack_i) irq_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cls_vote_unit.sv
// Directed bench for cls_vote_unit with default parameters (3 channels, threshold 4).
// Define CLS_FINJ_EN to also exercise the fault-injection path.
module tb_cls_vote_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        sample;
  logic [31:0] d0, d1, d2;
  logic        clear;
  logic        irq_ack;
  logic [31:0] voted;
  logic        voted_valid;
  logic        mismatch;
  logic [2:0]  ch_fault;
  logic [7:0]  err_cnt;
  logic [1:0]  state;
  logic        fail;
  logic        irq;
`ifdef CLS_FINJ_EN
  logic        finj_fault;
  logic [1:0]  finj_ch;
  logic [4:0]  finj_bit;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cls_vote_unit dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .enable_i     (enable),
    .sample_i     (sample),
    .ch_data_i    ({d2, d1, d0}),
    .clear_i      (clear),
    .irq_ack_i    (irq_ack),
`ifdef CLS_FINJ_EN
    .finj_fault_i (finj_fault),
    .finj_ch_i    (finj_ch),
    .finj_bit_i   (finj_bit),
`endif
    .voted_o      (voted),
    .voted_valid_o(voted_valid),
    .mismatch_o   (mismatch),
    .ch_fault_o   (ch_fault),
    .err_cnt_o    (err_cnt),
    .state_o      (state),
    .fail_o       (fail),
    .irq_o        (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one set of inputs, clock once, sample outputs 1 time unit after the edge.
  task automatic cyc(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                     input logic smp);
    d0 = a; d1 = b; d2 = c; sample = smp;
    @(posedge clk);
    #1;
    sample = 1'b0; clear = 1'b0; irq_ack = 1'b0; enable = 1'b1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] v, input logic vv,
                         input logic mm, input logic [2:0] f, input logic [7:0] e,
                         input logic [1:0] s, input logic fl, input logic iq);
    chk({tag, ".voted"},    voted,       v);
    chk({tag, ".valid"},    voted_valid, 32'(vv));
    chk({tag, ".mismatch"}, mismatch,    32'(mm));
    chk({tag, ".fault"},    ch_fault,    32'(f));
    chk({tag, ".err_cnt"},  err_cnt,     32'(e));
    chk({tag, ".state"},    state,       32'(s));
    chk({tag, ".fail"},     fail,        32'(fl));
    chk({tag, ".irq"},      irq,         32'(iq));
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; sample = 1'b0; clear = 1'b0; irq_ack = 1'b0;
    d0 = '0; d1 = '0; d2 = '0;
`ifdef CLS_FINJ_EN
    finj_fault = 1'b0; finj_ch = '0; finj_bit = '0;
`endif
    @(posedge clk); @(posedge clk); #1;
    chk_all("reset", 32'h0, 0, 0, 3'b000, 8'd0, 2'd0, 0, 0);
    rst_n = 1'b1;

    // Test 1: all channels agree.
    cyc(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1);
    chk_all("t1a", 32'hDEADBEEF, 1, 0, 3'b000, 8'd0, 2'd0, 0, 0);
    cyc(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 0);
    chk("t1.idle_valid", voted_valid, 32'd0);

    // Test 2: single transient disagreement on ch1.
    cyc(32'hDEADBEEF, 32'hDEADBEAF, 32'hDEADBEEF, 1);
    chk_all("t2a", 32'hDEADBEEF, 1, 1, 3'b000, 8'd1, 2'd1, 0, 0);
    cyc(32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1);
    chk_all("t2b", 32'hDEADBEEF, 1, 0, 3'b000, 8'd1, 2'd0, 0, 0);

    // Test 3: ch2 stuck at zero for four samples.
    cyc(32'h12345678, 32'h12345678, 32'h0, 1);
    chk_all("t3s1", 32'h12345678, 1, 1, 3'b000, 8'd2, 2'd1, 0, 0);
    cyc(32'h12345678, 32'h12345678, 32'h0, 1);
    cyc(32'h12345678, 32'h12345678, 32'h0, 1);
    chk_all("t3s3", 32'h12345678, 1, 1, 3'b000, 8'd4, 2'd1, 0, 0);
    cyc(32'h12345678, 32'h12345678, 32'h0, 1);
    chk_all("t3s4", 32'h12345678, 1, 1, 3'b100, 8'd5, 2'd2, 0, 1);
    cyc(32'h12345678, 32'h12345678, 32'h0, 1);
    chk_all("t3excl", 32'h12345678, 1, 0, 3'b100, 8'd5, 2'd2, 0, 1);
    irq_ack = 1'b1;
    cyc(32'h12345678, 32'h12345678, 32'h0, 0);
    chk("t3.ack_irq", irq, 32'd0);

    // Test 4: tie between remaining healthy channels, then clear.
    cyc(32'h1, 32'h2, 32'h0, 1);
    chk_all("t4fail", 32'h12345678, 0, 0, 3'b100, 8'd5, 2'd3, 1, 1);
    cyc(32'h5, 32'h6, 32'h7, 1);
    chk_all("t4hold", 32'h12345678, 0, 0, 3'b100, 8'd5, 2'd3, 1, 1);
    clear = 1'b1;
    cyc(32'h9, 32'h9, 32'h9, 1);
    chk_all("t4clr", 32'h12345678, 0, 0, 3'b000, 8'd0, 2'd0, 0, 0);

    // Test 5: enable low holds the counter mid-sequence.
    cyc(32'hA, 32'hB, 32'hA, 1);
    chk_all("t5m1", 32'hA, 1, 1, 3'b000, 8'd1, 2'd1, 0, 0);
    enable = 1'b0;
    cyc(32'hA, 32'hB, 32'hA, 1);
    chk_all("t5dis", 32'hA, 0, 0, 3'b000, 8'd1, 2'd1, 0, 0);
    cyc(32'hA, 32'hB, 32'hA, 1);
    cyc(32'hA, 32'hB, 32'hA, 1);
    chk_all("t5m3", 32'hA, 1, 1, 3'b000, 8'd3, 2'd1, 0, 0);
    cyc(32'hA, 32'hB, 32'hA, 1);
    chk_all("t5m4", 32'hA, 1, 1, 3'b010, 8'd4, 2'd2, 0, 1);
    irq_ack = 1'b1;
    cyc(32'hA, 32'hB, 32'hA, 0);
    chk("t5.ack_irq", irq, 32'd0);
    // Acknowledge coincident with FAIL entry: the set event wins.
    irq_ack = 1'b1;
    cyc(32'h1, 32'hB, 32'h2, 1);
    chk_all("t5ackfail", 32'hA, 0, 0, 3'b010, 8'd4, 2'd3, 1, 1);
    clear = 1'b1;
    cyc(32'h0, 32'h0, 32'h0, 0);
    chk_all("t5clr", 32'hA, 0, 0, 3'b000, 8'd0, 2'd0, 0, 0);

`ifdef CLS_FINJ_EN
    // Test 6: injected bit flip on ch1; out-of-range channel is ignored.
    finj_fault = 1'b1; finj_ch = 2'd1; finj_bit = 5'd31;
    cyc(32'h0, 32'h0, 32'h0, 1);
    chk_all("t6inj", 32'h0, 1, 1, 3'b000, 8'd1, 2'd1, 0, 0);
    finj_ch = 2'd3;
    cyc(32'h0, 32'h0, 32'h0, 1);
    chk_all("t6oor", 32'h0, 1, 0, 3'b000, 8'd1, 2'd0, 0, 0);
    finj_fault = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
